// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single write port of the 32x32 register file
// between ALU writeback (A, fixed priority) and load writeback (B, aged).
// Outputs are registered: a grant taken at one edge is presented to the
// register file for exactly one cycle and captured at the following edge.
module rf_write_arbiter #(
    parameter int unsigned MAX_WAIT     = 4,
    parameter bit          ZERO_PROTECT = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_A,
    input  logic [4:0]  ADDR_A,
    input  logic [31:0] DATA_A,
    output logic        ACK_A,
    input  logic        REQ_B,
    input  logic [4:0]  ADDR_B,
    input  logic [31:0] DATA_B,
    output logic        ACK_B,
    input  logic        HOLD,
    output logic        WR,
    output logic [4:0]  WR_ADDR,
    output logic [31:0] WR_DATA,
    output logic [31:0] WR_LOAD
);

    localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        wr_q, wr_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] wr_load_q, wr_load_d;
    logic [2:0]  wait_b_q, wait_b_d;

    logic        elig_a, elig_b;
    logic        grant_a, grant_b;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Arbitration, output staging and B aging for the next edge.
    always_comb begin
        // A request is ignored while its own acknowledge is still showing.
        elig_a  = REQ_A & ~ack_a_q;
        elig_b  = REQ_B & ~ack_b_q;

        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!HOLD) begin
            if (elig_b && (wait_b_q == WAIT_LIMIT)) begin
                grant_b = 1'b1;
            end else if (elig_a) begin
                grant_a = 1'b1;
            end else if (elig_b) begin
                grant_b = 1'b1;
            end
        end

        sel_addr  = grant_b ? ADDR_B : ADDR_A;
        sel_data  = grant_b ? DATA_B : DATA_A;

        ack_a_d   = grant_a;
        ack_b_d   = grant_b;

        // Address and data hold their last values when nothing is granted.
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_a || grant_b) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end

        // A granted r0 write is acknowledged but never strobed.
        wr_d      = (grant_a || grant_b) && !(ZERO_PROTECT && (sel_addr == 5'd0));
        wr_load_d = wr_d ? (32'd1 << sel_addr) : 32'd0;

        // B ages on every edge it is eligible but loses, HOLD edges included.
        wait_b_d  = wait_b_q;
        if (!REQ_B || grant_b) begin
            wait_b_d = 3'd0;
        end else if (elig_b && (wait_b_q < WAIT_LIMIT)) begin
            wait_b_d = wait_b_q + 3'd1;
        end
    end

    // State register; reset drops any in-flight write without a partial load.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
            wr_load_q <= 32'd0;
            wait_b_q  <= 3'd0;
        end else begin
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_load_q <= wr_load_d;
            wait_b_q  <= wait_b_d;
        end
    end

    assign ACK_A   = ack_a_q;
    assign ACK_B   = ack_b_q;
    assign WR      = wr_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;
    assign WR_LOAD = wr_load_q;

endmodule
